ctrl_decode_pipe: RTL and testbench

Next-generation decode/control unit for the WISC pipeline. It decodes the 5-bit opcode and 2-bit R-type funct into a control word and registers that word into the ID/EX boundary. It also owns the load-use interlock (stall plus bubble injection), the branch flush path, and a HALT drain state machine. It sits between the fetch/ID register and the execute stage.

---
 rtl/ctrl_decode_pipe.sv | 183 ++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe.sv
// WISC decode/control: opcode decode into a registered ID/EX control word,
// load-use interlock, branch flush and HALT drain sequencing.
module ctrl_decode_pipe #(
    parameter int ALUOP_W      = 3,
    parameter int REG_ADDR_W   = 3,
    parameter int HAZARD_EN    = 1,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [4:0]            id_opcode,
    input  logic [1:0]            id_funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_wr_reg,
    input  logic                  flush,
    output logic                  stall,
    output logic                  halted,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_jump,
    output logic                  ex_branch,
    output logic                  ex_zero_ext,
    output logic                  ex_inv_a,
    output logic                  ex_inv_b,
    output logic                  ex_cin,
    output logic                  ex_halt,
    output logic                  ex_illegal,
    output logic [1:0]            ex_alu_src,
    output logic [1:0]            ex_br_ctrl,
    output logic [ALUOP_W-1:0]    ex_alu_op,
    output logic [REG_ADDR_W-1:0] ex_wr_reg
);
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef struct packed {
        logic               regWrite;
        logic               memRead;
        logic               memWrite;
        logic               memToReg;
        logic               jump;
        logic               branch;
        logic               zeroExt;
        logic               invA;
        logic               invB;
        logic               cin;
        logic               halt;
        logic               illegal;
        logic [1:0]         aluSrc;
        logic [1:0]         brCtrl;
        logic [ALUOP_W-1:0] aluOp;
    } ctrlWord_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    ctrlWord_t             dec, exWord;
    logic                  usesRs, usesRt, stallHz, loadWord;
    logic                  exValid;
    logic [REG_ADDR_W-1:0] exWrReg;
    state_t                state;
    logic [CNT_W-1:0]      drainCnt;

    always_comb begin
        dec    = '0;
        usesRs = 1'b0;
        usesRt = 1'b0;
        casez (id_opcode)
            5'b00000: dec.halt = 1'b1;
            5'b00001: ;
            5'b010??: begin
                dec.aluSrc   = 2'b10;
                dec.regWrite = 1'b1;
                dec.aluOp    = ALUOP_W'(id_opcode[1:0]);
                dec.zeroExt  = id_opcode[1];
                dec.invA     = (id_opcode[1:0] == 2'b01);
                dec.cin      = (id_opcode[1:0] == 2'b01);
                dec.invB     = (id_opcode[1:0] == 2'b11);
                usesRs       = 1'b1;
            end
            5'b10000: begin
                dec.aluSrc   = 2'b10;
                dec.memWrite = 1'b1;
                usesRs       = 1'b1;
                usesRt       = 1'b1;
            end
            5'b10001: begin
                dec.aluSrc   = 2'b10;
                dec.memRead  = 1'b1;
                dec.memToReg = 1'b1;
                dec.regWrite = 1'b1;
                usesRs       = 1'b1;
            end
            5'b11011: begin
                dec.regWrite = 1'b1;
                dec.aluOp    = ALUOP_W'(id_funct);
                dec.invA     = (id_funct == 2'b01);
                dec.cin      = (id_funct == 2'b01);
                dec.invB     = (id_funct == 2'b11);
                usesRs       = 1'b1;
                usesRt       = 1'b1;
            end
            5'b011??: begin
                dec.branch = 1'b1;
                dec.aluSrc = 2'b01;
                dec.brCtrl = id_opcode[1:0];
                usesRs     = 1'b1;
            end
            5'b001??: begin
                dec.jump     = 1'b1;
                dec.regWrite = id_opcode[1];
                usesRs       = id_opcode[0];
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // The bubble this forces clears ex_mem_read, so a hazard stalls one cycle only.
    assign stallHz = (HAZARD_EN != 0) && id_valid && exValid && exWord.memRead &&
                     ((usesRs && (id_rs == exWrReg)) || (usesRt && (id_rt == exWrReg)));
    assign loadWord = (state == RUN) && !flush && !stallHz && id_valid;
    assign stall    = stallHz || (state != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exWord  <= '0;
            exValid <= 1'b0;
            exWrReg <= '0;
        end else if (loadWord) begin
            exWord  <= dec;
            exValid <= 1'b1;
            exWrReg <= id_wr_reg;
        end else begin
            exWord  <= '0;
            exValid <= 1'b0;
            exWrReg <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            drainCnt <= '0;
            halted   <= 1'b0;
        end else begin
            case (state)
                RUN: if (loadWord && dec.halt) begin
                    state    <= DRAIN;
                    drainCnt <= CNT_W'(DRAIN_CYCLES - 1);
                end
                DRAIN: if (drainCnt == '0) begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end else begin
                    drainCnt <= drainCnt - CNT_W'(1);
                end
                HALTED: halted <= 1'b1;
                default: state <= RUN;
            endcase
        end
    end

    assign ex_valid      = exValid;
    assign ex_reg_write  = exWord.regWrite;
    assign ex_mem_read   = exWord.memRead;
    assign ex_mem_write  = exWord.memWrite;
    assign ex_mem_to_reg = exWord.memToReg;
    assign ex_jump       = exWord.jump;
    assign ex_branch     = exWord.branch;
    assign ex_zero_ext   = exWord.zeroExt;
    assign ex_inv_a      = exWord.invA;
    assign ex_inv_b      = exWord.invB;
    assign ex_cin        = exWord.cin;
    assign ex_halt       = exWord.halt;
    assign ex_illegal    = exWord.illegal;
    assign ex_alu_src    = exWord.aluSrc;
    assign ex_br_ctrl    = exWord.brCtrl;
    assign ex_alu_op     = exWord.aluOp;
    assign ex_wr_reg     = exWrReg;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: decode table plus hazard, flush and HALT sequences.
module tb_ctrl_decode_pipe;
    typedef struct packed {
        logic v, rw, mr, mw, m2r, j, br, ze, ia, ib, ci, h, il;
        logic [1:0] src;
        logic [1:0] brc;
        logic [2:0] op;
        logic [2:0] wr;
    } exw_t;

    typedef struct {
        logic [4:0] opc;
        logic [1:0] fn;
        logic [2:0] rs, rt, wr;
        logic       vld, fl;
        exw_t       exp;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       id_valid, flush;
    logic [4:0] id_opcode;
    logic [1:0] id_funct;
    logic [2:0] id_rs, id_rt, id_wr_reg;

    logic stall, halted, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic ex_jump, ex_branch, ex_zero_ext, ex_inv_a, ex_inv_b, ex_cin, ex_halt, ex_illegal;
    logic [1:0] ex_alu_src, ex_br_ctrl;
    logic [2:0] ex_alu_op, ex_wr_reg;

    logic nzStall, nzHalted, nzValid, nzRegWrite, nzMemRead, nzMemWrite, nzMemToReg;
    logic nzJump, nzBranch, nzZeroExt, nzInvA, nzInvB, nzCin, nzHalt, nzIllegal;
    logic [1:0] nzAluSrc, nzBrCtrl;
    logic [2:0] nzAluOp, nzWrReg;

    exw_t obs;
    assign obs = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_jump,
                  ex_branch, ex_zero_ext, ex_inv_a, ex_inv_b, ex_cin, ex_halt, ex_illegal,
                  ex_alu_src, ex_br_ctrl, ex_alu_op, ex_wr_reg};

    ctrl_decode_pipe #(.ALUOP_W(3), .REG_ADDR_W(3), .HAZARD_EN(1), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_wr_reg(id_wr_reg), .flush(flush),
        .stall(stall), .halted(halted), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_zero_ext(ex_zero_ext),
        .ex_inv_a(ex_inv_a), .ex_inv_b(ex_inv_b), .ex_cin(ex_cin), .ex_halt(ex_halt),
        .ex_illegal(ex_illegal), .ex_alu_src(ex_alu_src), .ex_br_ctrl(ex_br_ctrl),
        .ex_alu_op(ex_alu_op), .ex_wr_reg(ex_wr_reg));

    ctrl_decode_pipe #(.ALUOP_W(3), .REG_ADDR_W(3), .HAZARD_EN(0), .DRAIN_CYCLES(2)) dutNoHz (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_wr_reg(id_wr_reg), .flush(flush),
        .stall(nzStall), .halted(nzHalted), .ex_valid(nzValid), .ex_reg_write(nzRegWrite),
        .ex_mem_read(nzMemRead), .ex_mem_write(nzMemWrite), .ex_mem_to_reg(nzMemToReg),
        .ex_jump(nzJump), .ex_branch(nzBranch), .ex_zero_ext(nzZeroExt),
        .ex_inv_a(nzInvA), .ex_inv_b(nzInvB), .ex_cin(nzCin), .ex_halt(nzHalt),
        .ex_illegal(nzIllegal), .ex_alu_src(nzAluSrc), .ex_br_ctrl(nzBrCtrl),
        .ex_alu_op(nzAluOp), .ex_wr_reg(nzWrReg));

    always #5 clk = ~clk;

    int   total = 0, passed = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic [4:0] opc, input logic [1:0] fn, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] wr, input logic vld,
                         input logic fl);
        id_opcode = opc; id_funct = fn; id_rs = rs; id_rt = rt; id_wr_reg = wr;
        id_valid = vld; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic [4:0] opc, input logic [1:0] fn, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [2:0] wr, input logic vld,
                          input logic fl, input exw_t e);
        vec_t t;
        t.opc = opc; t.fn = fn; t.rs = rs; t.rt = rt; t.wr = wr;
        t.vld = vld; t.fl = fl; t.exp = e;
        vecs.push_back(t);
    endtask

    initial begin
        exw_t e;
        drive(5'b00001, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);

        // opcode fn rs rt wr vld fl  expected EX word
        e = '{v:1'b1, rw:1'b1, src:2'b10, op:3'd1, ia:1'b1, ci:1'b1, wr:3'd2, default:'0};
        addVec(5'b01001, 2'b00, 3'd1, 3'd0, 3'd2, 1'b1, 1'b0, e);   // SUBI
        e = '{v:1'b1, rw:1'b1, src:2'b10, op:3'd3, ze:1'b1, ib:1'b1, wr:3'd3, default:'0};
        addVec(5'b01011, 2'b00, 3'd1, 3'd0, 3'd3, 1'b1, 1'b0, e);   // ANDNI
        e = '{v:1'b1, rw:1'b1, src:2'b10, op:3'd0, wr:3'd4, default:'0};
        addVec(5'b01000, 2'b00, 3'd2, 3'd0, 3'd4, 1'b1, 1'b0, e);   // ADDI
        e = '{v:1'b1, rw:1'b1, src:2'b10, op:3'd2, ze:1'b1, wr:3'd5, default:'0};
        addVec(5'b01010, 2'b00, 3'd2, 3'd0, 3'd5, 1'b1, 1'b0, e);   // XORI
        e = '{v:1'b1, mw:1'b1, src:2'b10, default:'0};
        addVec(5'b10000, 2'b00, 3'd1, 3'd2, 3'd0, 1'b1, 1'b0, e);   // ST
        e = '{v:1'b1, rw:1'b1, mr:1'b1, m2r:1'b1, src:2'b10, wr:3'd4, default:'0};
        addVec(5'b10001, 2'b00, 3'd1, 3'd0, 3'd4, 1'b1, 1'b0, e);   // LD
        e = '{v:1'b1, rw:1'b1, op:3'd1, ia:1'b1, ci:1'b1, wr:3'd7, default:'0};
        addVec(5'b11011, 2'b01, 3'd5, 3'd6, 3'd7, 1'b1, 1'b0, e);   // R SUB
        e = '{v:1'b1, rw:1'b1, op:3'd3, ib:1'b1, wr:3'd1, default:'0};
        addVec(5'b11011, 2'b11, 3'd5, 3'd6, 3'd1, 1'b1, 1'b0, e);   // R ANDN
        e = '{v:1'b1, br:1'b1, src:2'b01, brc:2'b01, default:'0};
        addVec(5'b01101, 2'b00, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, e);   // branch
        e = '{v:1'b1, j:1'b1, default:'0};
        addVec(5'b00100, 2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, e);   // J
        e = '{v:1'b1, j:1'b1, rw:1'b1, wr:3'd7, default:'0};
        addVec(5'b00110, 2'b00, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, e);   // JAL
        e = '{v:1'b1, default:'0};
        addVec(5'b00001, 2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, e);   // NOP
        e = '{v:1'b1, il:1'b1, default:'0};
        addVec(5'b11111, 2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, e);   // illegal
        addVec(5'b10010, 2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, e);   // illegal
        e = '0;
        addVec(5'b01000, 2'b00, 3'd1, 3'd0, 3'd2, 1'b0, 1'b0, e);   // not valid
        addVec(5'b10000, 2'b00, 3'd1, 3'd2, 3'd0, 1'b1, 1'b1, e);   // flushed ST

        #3;
        check("reset_ex", obs, 0);
        check("reset_stall", stall, 0);
        check("reset_halted", halted, 0);
        step();
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].opc, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].wr,
                  vecs[i].vld, vecs[i].fl);
            #2 check($sformatf("vec%0d_stall", i), stall, 0);
            step();
            check($sformatf("vec%0d_ex", i), obs, vecs[i].exp);
        end

        // load-use on rs: one-cycle stall, bubble, then the R-type lands
        drive(5'b10001, 2'b00, 3'd1, 3'd0, 3'd3, 1'b1, 1'b0);
        step();
        check("ld_memread", ex_mem_read, 1);
        drive(5'b11011, 2'b00, 3'd3, 3'd4, 3'd5, 1'b1, 1'b0);
        #2 check("hz_rs_stall", stall, 1);
        check("nohz_stall", nzStall, 0);
        step();
        check("hz_bubble", ex_valid, 0);
        check("nohz_loaded", nzValid, 1);
        #2 check("hz_one_cycle", stall, 0);
        step();
        check("hz_resume", {ex_valid, ex_reg_write, ex_wr_reg}, {2'b11, 3'd5});

        // load-use on rt (ST uses rt)
        drive(5'b10001, 2'b00, 3'd1, 3'd0, 3'd3, 1'b1, 1'b0);
        step();
        drive(5'b10000, 2'b00, 3'd1, 3'd3, 3'd0, 1'b1, 1'b0);
        #2 check("hz_rt_stall", stall, 1);
        step();
        check("hz_rt_bubble", {ex_valid, ex_mem_write}, 0);
        step();
        check("hz_rt_resume", {ex_valid, ex_mem_write}, 2'b11);

        // rt matches but ADDI does not read rt
        drive(5'b10001, 2'b00, 3'd1, 3'd0, 3'd3, 1'b1, 1'b0);
        step();
        drive(5'b01000, 2'b00, 3'd5, 3'd3, 3'd6, 1'b1, 1'b0);
        #2 check("no_hz_rt_unused", stall, 0);
        step();
        check("no_hz_loaded", ex_valid, 1);

        // flush together with a hazard
        drive(5'b10001, 2'b00, 3'd1, 3'd0, 3'd3, 1'b1, 1'b0);
        step();
        drive(5'b11011, 2'b00, 3'd3, 3'd4, 3'd5, 1'b1, 1'b1);
        #2 check("flush_hz_stall", stall, 1);
        step();
        check("flush_hz_bubble", obs, 0);

        // flushed HALT is discarded
        drive(5'b00000, 2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        check("flush_halt_ex", {ex_valid, ex_halt}, 0);
        drive(5'b00001, 2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        #2 check("flush_halt_run", stall, 0);
        step();
        step();
        check("flush_halt_not_halted", {halted, stall}, 0);

        // HALT drain: edge N loads HALT, halted at N+2
        drive(5'b00000, 2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        #2 check("halt_pre_stall", stall, 0);
        step();
        check("halt_N", {ex_valid, ex_halt, stall, halted}, 4'b1110);
        drive(5'b01000, 2'b00, 3'd1, 3'd0, 3'd2, 1'b1, 1'b0);
        step();
        check("halt_N1", {ex_valid, stall, halted}, 3'b010);
        step();
        check("halt_N2", {ex_valid, stall, halted}, 3'b011);
        drive(5'b01000, 2'b00, 3'd1, 3'd0, 3'd2, 1'b1, 1'b1);
        step();
        step();
        check("halted_hold", {ex_valid, stall, halted}, 3'b011);

        // asynchronous reset out of HALTED, then again mid-drain
        #2 rst = 1'b1;
        #1 check("rst_halted_async", {stall, halted, ex_valid}, 0);
        step();
        rst = 1'b0;
        drive(5'b00000, 2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        step();
        drive(5'b00001, 2'b00, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        #2 check("drain_stall", stall, 1);
        rst = 1'b1;
        #1 check("rst_drain_async", {stall, halted, ex_halt}, 0);
        #1 rst = 1'b0;
        drive(5'b01000, 2'b00, 3'd1, 3'd0, 3'd2, 1'b1, 1'b0);
        #1 check("post_rst_run", stall, 0);
        step();
        check("post_rst_load", {ex_valid, ex_reg_write, halted}, 3'b110);
        step();
        step();
        check("post_rst_no_halt", halted, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
